// File: rtl/aes_xif_scheduler.sv
// aes_xif_scheduler: in-order queue between CV-X-IF offload and a shared AES round engine
module aes_xif_scheduler #(
    parameter int X_ID_WIDTH = 4,
    parameter int DEPTH      = 4,
    parameter int OP_WIDTH   = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        issue_valid_i,
    output logic                        issue_ready_o,
    input  logic [X_ID_WIDTH-1:0]       issue_id_i,
    input  logic [OP_WIDTH-1:0]         issue_op_i,
    input  logic [31:0]                 issue_rs1_i,
    input  logic [31:0]                 issue_rs2_i,
    input  logic [4:0]                  issue_rd_i,
    input  logic                        commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]       commit_id_i,
    input  logic                        commit_kill_i,
    output logic                        eng_start_o,
    output logic [OP_WIDTH-1:0]         eng_op_o,
    output logic [31:0]                 eng_rs1_o,
    output logic [31:0]                 eng_rs2_o,
    input  logic                        eng_done_i,
    input  logic [31:0]                 eng_result_i,
    output logic                        result_valid_o,
    input  logic                        result_ready_i,
    output logic [X_ID_WIDTH-1:0]       result_id_o,
    output logic [4:0]                  result_rd_o,
    output logic [31:0]                 result_data_o,
    output logic [$clog2(DEPTH):0]      occupancy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;
    state_t state, state_nxt;

    logic [PW-1:0]         rptr, wptr, occ;
    logic [AW-1:0]         head, hit_idx;
    logic [X_ID_WIDTH-1:0] e_id  [DEPTH];
    logic [OP_WIDTH-1:0]   e_op  [DEPTH];
    logic [31:0]           e_rs1 [DEPTH];
    logic [31:0]           e_rs2 [DEPTH];
    logic [4:0]            e_rd  [DEPTH];
    logic [DEPTH-1:0]      e_cmt, e_kil;
    logic [31:0]           res_q;
    logic                  full, push, pop, kill_pop, resp_pop, hit, new_hit, head_valid;

    assign occ            = wptr - rptr;
    assign occupancy_o    = occ;
    assign full           = occ == PW'(DEPTH);
    assign issue_ready_o  = !full;
    assign push           = issue_valid_i && !full;
    assign head           = rptr[AW-1:0];
    assign head_valid     = occ != '0;
    assign pop            = kill_pop || resp_pop;
    assign eng_op_o       = e_op[head];
    assign eng_rs1_o      = e_rs1[head];
    assign eng_rs2_o      = e_rs2[head];
    assign result_valid_o = state == RESP;
    assign result_id_o    = e_id[head];
    assign result_rd_o    = e_rd[head];
    assign result_data_o  = res_q;

    // Oldest uncommitted in-flight entry with a matching ID, scanned from the head
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!hit && PW'(k) < occ && !e_cmt[head + AW'(k)] && e_id[head + AW'(k)] == commit_id_i) begin
                hit     = 1'b1;
                hit_idx = head + AW'(k);
            end
        end
    end

    // IDs are unique in flight, so an in-queue match excludes the entry being pushed
    assign new_hit = commit_valid_i && !hit && push && issue_id_i == commit_id_i;

    always_comb begin
        state_nxt   = state;
        eng_start_o = 1'b0;
        kill_pop    = 1'b0;
        resp_pop    = 1'b0;
        case (state)
            IDLE: begin
                if (head_valid && e_cmt[head]) begin
                    kill_pop  = e_kil[head];
                    state_nxt = e_kil[head] ? IDLE : START;
                end
            end
            START: begin
                eng_start_o = 1'b1;
                state_nxt   = BUSY;
            end
            BUSY: state_nxt = eng_done_i ? RESP : BUSY;
            RESP: begin
                resp_pop  = result_ready_i;
                state_nxt = result_ready_i ? IDLE : RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            rptr  <= '0;
            wptr  <= '0;
            res_q <= '0;
            e_cmt <= '0;
            e_kil <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_id[i]  <= '0;
                e_op[i]  <= '0;
                e_rs1[i] <= '0;
                e_rs2[i] <= '0;
                e_rd[i]  <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == BUSY && eng_done_i)
                res_q <= eng_result_i;
            if (commit_valid_i && hit) begin
                e_cmt[hit_idx] <= 1'b1;
                e_kil[hit_idx] <= commit_kill_i;
            end
            if (push) begin
                e_id[wptr[AW-1:0]]  <= issue_id_i;
                e_op[wptr[AW-1:0]]  <= issue_op_i;
                e_rs1[wptr[AW-1:0]] <= issue_rs1_i;
                e_rs2[wptr[AW-1:0]] <= issue_rs2_i;
                e_rd[wptr[AW-1:0]]  <= issue_rd_i;
                e_cmt[wptr[AW-1:0]] <= new_hit;
                e_kil[wptr[AW-1:0]] <= new_hit && commit_kill_i;
                wptr                <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end
endmodule
